// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_radix2_iter.sv
// Iterative unsigned restoring divider core: one quotient bit per clock, ITER clocks per divide.
module div_radix2_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CW = $clog2(ITER + 1);

  logic [2*WIDTH-1:0] r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic [CW-1:0]      r_count;
  logic               r_busy;

  logic [2*WIDTH:0]   w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_fits;

  // Upper half holds the partial remainder, lower half shifts dividend bits out and quotient bits in.
  always_comb begin
    w_shift = {r_rem, 1'b0};
    w_fits  = w_shift[2*WIDTH:WIDTH] >= {1'b0, r_divisor};
    w_diff  = w_shift[2*WIDTH-1:WIDTH] - r_divisor;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
    end else if (i_start) begin
      r_rem     <= {{WIDTH{1'b0}}, i_dividend};
      r_divisor <= i_divisor;
      r_count   <= '0;
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      r_rem   <= w_fits ? {w_diff, w_shift[WIDTH-1:1], 1'b1} : w_shift[2*WIDTH-1:0];
      r_count <= r_count + CW'(1);
      if (r_count == CW'(ITER - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_quotient  = r_rem[WIDTH-1:0];
  assign o_remainder = r_rem[2*WIDTH-1:WIDTH];
  assign o_done      = r_busy & (r_count == CW'(ITER - 1));

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO execute-stage unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO with pipeline stall.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier, no stall for MULT/MULTU.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  localparam int CW = $clog2(ITER + 1);

  state_e             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;

  logic               w_isMulOp;
  logic               w_isDivOp;
  logic               w_isIterOp;
  logic               w_signedOp;
  logic               w_aNeg;
  logic               w_bNeg;
  logic               w_accept;
  logic               w_divStart;
  logic               w_divDone;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quotSel;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastA;
  logic [2*WIDTH-1:0] w_fastB;
  logic [2*WIDTH-1:0] w_fastProd;
`else
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_prodFix;
`endif

  // Operand decode and sign handling: signed ops run on magnitudes and fix signs at commit.
  always_comb begin
    w_isMulOp  = (op == OP_MULT) | (op == OP_MULTU);
    w_isDivOp  = (op == OP_DIV)  | (op == OP_DIVU);
`ifdef MULDIV_FAST_MUL_EN
    w_isIterOp = w_isDivOp;
`else
    w_isIterOp = w_isMulOp | w_isDivOp;
`endif
    w_signedOp = (op == OP_MULT) | (op == OP_DIV);
    w_aNeg     = w_signedOp & src_a[WIDTH-1];
    w_bNeg     = w_signedOp & src_b[WIDTH-1];
    w_aMag     = w_aNeg ? -src_a : src_a;
    w_bMag     = w_bNeg ? -src_b : src_b;
    w_accept   = op_valid & !flush & (r_state == S_IDLE);
    w_divStart = w_accept & w_isDivOp;
  end

  always_comb begin
    w_quotSel = r_divZero ? DIV0_QUOT[WIDTH-1:0] : w_quot;
    w_quotFix = r_negRes ? -w_quotSel : w_quotSel;
    w_remFix  = r_negRem ? -w_rem : w_rem;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    w_fastA    = w_signedOp ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    w_fastB    = w_signedOp ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    w_fastProd = w_fastA * w_fastB;
  end
`else
  always_comb begin
    w_mulSum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    w_prodFix = r_negRes ? -r_prod : r_prod;
  end
`endif

  div_radix2_iter #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_divStart),
    .i_dividend  (w_aMag),
    .i_divisor   (w_bMag),
    .o_quotient  (w_quot),
    .o_remainder (w_rem),
    .o_done      (w_divDone)
  );

  // Control FSM; flush wins over everything except reset and leaves HI/LO untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      r_mcand   <= '0;
      r_prod    <= '0;
`endif
    end else if (flush) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MTHI) begin
              r_hi <= src_a;
            end else if (op == OP_MTLO) begin
              r_lo <= src_a;
`ifdef MULDIV_FAST_MUL_EN
            end else if (w_isMulOp) begin
              {r_hi, r_lo} <= w_fastProd;
`endif
            end else if (w_isIterOp) begin
              r_isDiv   <= w_isDivOp;
              r_negRes  <= w_aNeg ^ w_bNeg;
              r_negRem  <= w_aNeg;
              r_divZero <= (src_b == '0);
              r_count   <= '0;
              r_state   <= S_RUN;
`ifndef MULDIV_FAST_MUL_EN
              r_mcand   <= w_aMag;
              r_prod    <= {{WIDTH{1'b0}}, w_bMag};
`endif
            end
          end
        end
        S_RUN: begin
          r_count <= r_count + CW'(1);
`ifndef MULDIV_FAST_MUL_EN
          if (!r_isDiv) begin
            r_prod <= r_prod[0] ? {w_mulSum, r_prod[WIDTH-1:1]} : {1'b0, r_prod[2*WIDTH-1:1]};
          end
`endif
          if (r_isDiv ? w_divDone : (r_count == CW'(ITER - 1))) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef MULDIV_FAST_MUL_EN
          r_lo <= w_quotFix;
          r_hi <= w_remFix;
`else
          if (r_isDiv) begin
            r_lo <= w_quotFix;
            r_hi <= w_remFix;
          end else begin
            {r_hi, r_lo} <= w_prodFix;
          end
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = resetn & !flush &
                   ((r_state == S_RUN) | ((r_state == S_IDLE) & op_valid & w_isIterOp));
  assign busy_o  = (r_state != S_IDLE);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Execute-stage responder for the HI/LO class of instructions flagged by the main decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI and LO registers and runs an iterative radix-2 divider and multiplier.
- Stalls the pipeline until a result is ready, then commits HI/LO in one cycle.
- MFHI and MFLO read hi_o/lo_o directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- op_valid  in  1  EX-stage instruction is a HI/LO operation; held stable by the pipeline while stall_o=1.
- op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- src_a  in  WIDTH  rs value; dividend / multiplicand / MTHI-MTLO data.
- src_b  in  WIDTH  rt value; divisor / multiplier.
- flush  in  1  exception or eret flush; aborts the operation in flight.
- stall_o  out  1  hold the pipeline.
- hi_o  out  WIDTH  architectural HI.
- lo_o  out  WIDTH  architectural LO.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (resetn=0 at clock edge): hi_o=0, lo_o=0, state=IDLE, counter=0, stall_o=0, busy_o=0. Reset overrides every other input, including mid-operation.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - MTHI/MTLO with op_valid & !flush: write src_a into HI or LO at that edge. No stall. The other register is unchanged.
  - MULT/MULTU/DIV/DIVU with op_valid & !flush: latch operands. Record sign flags; signed ops use absolute values internally. Set counter=0 and go to RUN.
  - stall_o = op_valid & (op<=3) in the accept cycle (combinational).
- RUN:
  - One iteration per cycle; counter increments.
  - Divide: restoring shift-subtract on a 2*WIDTH remainder register.
  - Multiply: shift-add on a 2*WIDTH product register.
  - After ITER iterations, go to DONE. stall_o=1 throughout RUN.
- DONE:
  - stall_o=0 for exactly one cycle.
  - At the edge ending DONE: HI/LO are written, state goes to IDLE.
  - Multiply: {HI,LO}=product. Signed MULT negates the 64-bit product if the sign flags differ.
  - Divide: LO=quotient, HI=remainder.
  - Signed divide sign rules: quotient negated if signs differ; remainder takes the dividend's sign.
- Timing: total stall is ITER+1 cycles (accept + 32 RUN). The instruction advances after the DONE cycle.
- Divide by zero: no exception. LO=0xFFFFFFFF and HI=dividend (unsigned magnitude path). For DIV, sign correction applies to the quotient/remainder as above.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Flush: in any state, go to IDLE next edge. HI/LO are unchanged, the partial result is discarded and stall_o=0 in that cycle. In IDLE, flush suppresses MTHI/MTLO and accept.
- No new op is accepted in RUN or DONE. op/src changes during RUN are ignored (operands already latched).
- Forwarding: hi_o/lo_o always show committed registers. An MFHI/MFLO following a multiply or divide sees the new value because of the stall.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle 32x32 multiplier. {HI,LO} are written at the accept edge; no stall, no FSM transition. DIV/DIVU are unchanged.
- Undefined: multiply uses the iterative path with ITER+1 stall cycles, identical to divide.

Decomposition:
- Shared package muldiv_pkg holds:
  - op codes OP_MULT..OP_MTLO;
  - state encodings S_IDLE/S_RUN/S_DONE;
  - DIV0_QUOT constant 0xFFFFFFFF.
- One sub-module, div_radix2_iter: the iterative unsigned divider core. Interface: start, dividend, divisor, quotient, remainder, done. The top handles signs and multiply.

Test Plan:
- Reset: hold resetn=0 during a DIV in RUN -> hi_o=lo_o=0, stall_o=0, busy_o=0 on the next cycle.
- MULT (mult path, both macro builds):
  - src_a=0xFFFFFFFD (-3), src_b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Stall lasts 33 cycles without the macro, 0 with it.
- MULTU: 0xFFFFFFFF*2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV:
  - -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
  - Also DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678, no exception.
- Flush and MTHI/MTLO:
  - Flush on RUN cycle 10 of a DIV with HI=0xAAAA0000 preset via MTHI -> state IDLE next cycle, HI unchanged.
  - A following MTLO 0x55 writes LO in one cycle with no stall.
